// File: rtl/divider_pkg.sv
// Shared types and widths for the 8-bit by 4-bit restoring divider.
package divider_pkg;

  localparam int unsigned DividendW = 8;
  localparam int unsigned DivisorW  = 4;
  localparam int unsigned CountW    = 3;

  // Iteration counter load value: DividendW quotient bits, counted down to zero.
  localparam logic [CountW-1:0] LastIter = CountW'(DividendW - 1);

  // Quotient reported when the divisor is zero.
  localparam logic [DividendW-1:0] QuotDivZero = {DividendW{1'b1}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor, keep or restore.
module div_step
  import divider_pkg::*;
(
  input  logic [DivisorW:0]   i_trial,
  input  logic [DivisorW-1:0] i_divisor,
  output logic [DivisorW-1:0] o_rem,
  output logic                o_qbit
);

  logic [DivisorW:0] w_diff;
  logic [DivisorW:0] w_divisor_ext;

  assign w_divisor_ext = {1'b0, i_divisor};
  assign w_diff        = i_trial - w_divisor_ext;

  // Partial remainder stays below the divisor, so either branch fits in DivisorW bits.
  always_comb begin
    o_qbit = (i_trial >= w_divisor_ext);
    if (o_qbit) begin
      o_rem = w_diff[DivisorW-1:0];
    end else begin
      o_rem = i_trial[DivisorW-1:0];
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential unsigned divider: one quotient bit per clock, MSB first, registered outputs.
module divider
  import divider_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DividendW-1:0] dividend,
  input  logic [DivisorW-1:0]  divisor,
  output logic [DividendW-1:0] quotient,
  output logic [DivisorW-1:0]  remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  state_e               r_state;
  logic [DividendW-1:0] r_dvd;
  logic [DivisorW-1:0]  r_dvs;
  logic [DivisorW-1:0]  r_rem;
  logic [CountW-1:0]    r_count;
  logic [DividendW-1:0] r_quot;
  logic [DivisorW-1:0]  r_rem_out;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;

  state_e               w_state_next;
  logic [DividendW-1:0] w_dvd_next;
  logic [DivisorW-1:0]  w_dvs_next;
  logic [DivisorW-1:0]  w_rem_next;
  logic [CountW-1:0]    w_count_next;
  logic [DividendW-1:0] w_quot_next;
  logic [DivisorW-1:0]  w_rem_out_next;
  logic                 w_dbz_next;

  logic [DivisorW:0]    w_trial;
  logic [DivisorW-1:0]  w_step_rem;
  logic                 w_step_qbit;

  // r_dvd doubles as the quotient shift register: dividend bits leave at the top,
  // quotient bits enter at the bottom.
  assign w_trial = {r_rem, r_dvd[DividendW-1]};

  div_step u_div_step (
    .i_trial   (w_trial),
    .i_divisor (r_dvs),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_qbit)
  );

  always_comb begin
    w_state_next   = r_state;
    w_dvd_next     = r_dvd;
    w_dvs_next     = r_dvs;
    w_rem_next     = r_rem;
    w_count_next   = r_count;
    w_quot_next    = r_quot;
    w_rem_out_next = r_rem_out;
    w_dbz_next     = r_dbz;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_dvd_next   = dividend;
          w_dvs_next   = divisor;
          w_rem_next   = '0;
          w_count_next = LastIter;
          w_dbz_next   = 1'b0;
          if (divisor == '0) begin
            w_state_next   = StDone;
            w_quot_next    = QuotDivZero;
            w_rem_out_next = dividend[DivisorW-1:0];
            w_dbz_next     = 1'b1;
          end else begin
            w_state_next = StBusy;
          end
        end
      end
      StBusy: begin
        w_dvd_next   = {r_dvd[DividendW-2:0], w_step_qbit};
        w_rem_next   = w_step_rem;
        w_count_next = r_count - 1'b1;
        if (r_count == '0) begin
          w_state_next   = StDone;
          w_quot_next    = {r_dvd[DividendW-2:0], w_step_qbit};
          w_rem_out_next = w_step_rem;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_dvd     <= w_dvd_next;
      r_dvs     <= w_dvs_next;
      r_rem     <= w_rem_next;
      r_count   <= w_count_next;
      r_quot    <= w_quot_next;
      r_rem_out <= w_rem_out_next;
      r_busy    <= (w_state_next == StBusy);
      r_done    <= (w_state_next == StDone);
      r_dbz     <= w_dbz_next;
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expected results queued at start, checked on done.
module tb_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_done;
  int   n_checks;
  int   n_fail;

  divider u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [7:0] dvd, input logic [3:0] dvs);
    exp_t e;
    if (dvs == 4'd0) begin
      e.q   = 8'hFF;
      e.r   = dvd[3:0];
      e.dbz = 1'b1;
    end else begin
      e.q   = dvd / {4'd0, dvs};
      e.r   = 4'(dvd % {4'd0, dvs});
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Result checks on every done pulse; done must never be wider than one cycle.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_eq("extra_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("quotient", 32'(quotient), 32'(mon_e.q));
        check_eq("remainder", 32'(remainder), 32'(mon_e.r));
        check_eq("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
      end
    end
    if (done && prev_done) check_eq("done_width", 32'd2, 32'd1);
    prev_done <= done;
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_div(input logic [7:0] dvd, input logic [3:0] dvs);
    exp_t e;
    int   lat;
    e        = model(dvd, dvs);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    check_eq("dbz_at_e0", 32'(div_by_zero), 32'(dvs == 4'd0));
    if (dvs != 4'd0) check_eq("busy_e0", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", 32'(lat), (dvs == 4'd0) ? 32'd1 : 32'd9);
    @(posedge clk);
    #1;
    check_eq("idle_flags", {30'd0, busy, done}, 32'd0);
    check_eq("hold_q", 32'(quotient), 32'(e.q));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    n_checks  = 0;
    n_fail    = 0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b1;
    dividend  = 8'd55;
    divisor   = 4'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_q", 32'(quotient), 32'd0);
    check_eq("rst_r", 32'(remainder), 32'd0);
    check_eq("rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);

    // First start accepted on the first edge with reset released.
    rst_n = 1'b1;
    do_div(8'd200, 4'd7);
    do_div(8'd255, 4'd1);
    do_div(8'd15, 4'd15);
    do_div(8'd3, 4'd9);
    do_div(8'd9, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("dbz_hold", 32'(div_by_zero), 32'd1);
    check_eq("dbz_hold_r", 32'(remainder), 32'd9);
    do_div(8'd77, 4'd6);

    // Start pulsed mid-operation is ignored.
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    sb.push_back(model(8'd100, 4'd3));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("busy_e3", 32'(busy), 32'd1);
    lat = 4;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency_ign", 32'(lat), 32'd9);
    repeat (15) @(posedge clk);
    @(negedge clk);

    // Reset aborts an operation in flight.
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_q", 32'(quotient), 32'd0);
    check_eq("abort_r", 32'(remainder), 32'd0);
    check_eq("abort_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    do_div(8'd14, 4'd2);

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div(8'(a), 4'(b));
      end
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have no parameters; the dividend is fixed at 8 bits and the divisor at 4 bits, matching the team's 4x4 product width.
REQ-002 SHALL have exactly one clock, clk; reset is synchronous and active-low, named rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 dividend  input  8  unsigned dividend; captured when start is accepted.
REQ-007 divisor  input  4  unsigned divisor; captured when start is accepted.
REQ-008 quotient  output  8  unsigned quotient, registered.
REQ-009 remainder  output  4  unsigned remainder, registered.
REQ-010 busy  output  1  high while a division is in progress (BUSY state).
REQ-011 done  output  1  single-cycle pulse; quotient and remainder are valid from this cycle onward.
REQ-012 div_by_zero  output  1  set with done when the captured divisor is 0; held until the next accepted start.

Function
REQ-013 SHALL implement a restoring unsigned divide producing one quotient bit per clock, MSB first.
REQ-014 SHALL use the FSM states IDLE, BUSY and DONE.
REQ-015 IDLE: start=1 at edge E0 SHALL capture the operands, clear the partial remainder, load the iteration count 7, and go to BUSY (busy=1 from E0).
REQ-016 BUSY: each edge SHALL do four things:
  - shift {partial remainder, dividend MSB} left into a 5-bit trial value;
  - subtract {1'b0, divisor};
  - if the result is non-negative, keep it and shift in quotient bit 1;
  - otherwise restore and shift in 0.
REQ-017 After the 8th iteration (edge E8), the FSM SHALL go to DONE and update quotient/remainder; done=1 and busy=0 for exactly the cycle after E8.
REQ-018 DONE SHALL return to IDLE unconditionally on the next edge (E9); done=0 thereafter.
REQ-019 Latency from accepted start to done SHALL be 9 clocks; throughput SHALL be one division per 10 clocks when start is held high.
REQ-020 start asserted in BUSY or DONE SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-021 Operand inputs SHALL be don't-care outside the accepting edge; changing them mid-operation SHALL NOT affect the result.
REQ-022 divisor=0 SHALL skip BUSY: E0 goes IDLE->DONE, then done=1 and div_by_zero=1 with quotient=8'hFF and remainder=dividend[3:0].
REQ-023 quotient, remainder and div_by_zero SHALL hold their last values from DONE until the next accepted start; on that start, div_by_zero SHALL clear at E0.
REQ-024 The result SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for every nonzero divisor.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force all of the following: state IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, internal registers 0.
REQ-026 Reset SHALL take priority over start and over an operation in progress; an aborted division SHALL produce no done pulse.
REQ-027 The first start SHALL be accepted on the first edge at which rst_n=1.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/BUSY/DONE) and the width constants (dividend 8, divisor 4, count 3).
REQ-029 The trial subtract/restore SHALL be a combinational sub-module div_step with these ports:
  - inputs: 5-bit trial, 4-bit divisor;
  - outputs: 4-bit next remainder, 1-bit quotient bit.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational input-to-output path.

Verification
REQ-031 dividend=200, divisor=7 -> done 9 clocks after start; quotient=28, remainder=4, div_by_zero=0.
REQ-032 dividend=255, divisor=1 -> quotient=255, remainder=0; dividend=15, divisor=15 -> quotient=1, remainder=0; dividend=3, divisor=9 -> quotient=0, remainder=3.
REQ-033 dividend=9, divisor=0 -> done 1 clock after start; div_by_zero=1, quotient=8'hFF, remainder=9.
REQ-034 Start 100/3, then pulse start with 50/5 at edge E3 -> first result only (quotient=33, remainder=1); no extra done pulse.
REQ-035 Start 200/7, then drive rst_n=0 at E4 -> all outputs 0, no done pulse; a new start of 14/2 after reset -> quotient=7, remainder=0.
REQ-036 Exhaustive sweep of all 256x15 nonzero pairs -> REQ-024 holds and every done pulse is exactly 1 cycle wide.
